fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 91 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and beat-counter width for the FIFO write arbiter.
package fifo_arb_pkg;
  localparam int BEAT_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pointer plus one-hot/index selection of the next owner.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            wr_clk,
  input  logic            wr_rstn,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  logic [IW-1:0] ptr_q, ptr_d, c;
  always_comb begin
    c = '0;
    idx_o = '0;
    // Descending scan so the requester closest to the pointer wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = IW'((int'(ptr_q) + k) % NREQ);
      if (req_i[c]) idx_o = c;
    end
    gnt_o = req_i[idx_o] ? NREQ'(1) << idx_o : '0;
    ptr_d = adv_i ? (idx_o == IW'(NREQ - 1) ? '0 : idx_o + 1'b1) : ptr_q;
  end
  always_ff @(posedge wr_clk or negedge wr_rstn)
    if (!wr_rstn) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding a FIFO write port with a registered, stall-holding output.
// Optional saturating beat/stall counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    wr_clk,
  input  logic                    wr_rstn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_wr_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]             stat_beats,
  output logic [15:0]             stat_stalls
`endif
);
  localparam int IW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] gid_q, gid_d, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [WIDTH-1:0] data_q, data_d;
  logic wr_en_q, wr_en_d, stall, xfer, done, adv;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .wr_clk (wr_clk),
    .wr_rstn(wr_rstn),
    .req_i  (req_valid),
    .adv_i  (adv),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );
  always_comb begin
    stall = wr_en_q && fifo_full;
    xfer = state_q == XFER && req_valid[gid_q] && !stall;
    done = xfer && (req_last[gid_q] || cnt_q == BEAT_CNT_W'(MAX_BURST - 1));
    adv = state_q == IDLE && |arb_gnt;
    gid_d = adv ? arb_idx : gid_q;
    cnt_d = adv ? '0 : xfer ? cnt_q + 1'b1 : cnt_q;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = adv ? XFER : IDLE;
      XFER: state_d = done ? IDLE : stall ? HOLD : XFER;
      HOLD: state_d = fifo_full ? HOLD : XFER;
      default: state_d = IDLE;
    endcase
    wr_en_d = xfer || stall;
    data_d = xfer ? req_data[gid_q*WIDTH +: WIDTH] : data_q;
  end
  always_ff @(posedge wr_clk or negedge wr_rstn)
    if (!wr_rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gid_q <= '0;
      wr_en_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gid_q <= gid_d;
      wr_en_q <= wr_en_d;
      data_q <= data_d;
    end
  assign req_ready = xfer ? NREQ'(1) << gid_q : '0;
  assign fifo_wr_en = wr_en_q;
  assign fifo_wr_data = data_q;
  assign grant_id = gid_q;
  assign busy = state_q != IDLE;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] beats_q, stalls_q;
  always_ff @(posedge wr_clk or negedge wr_rstn)
    if (!wr_rstn) begin
      beats_q <= '0;
      stalls_q <= '0;
    end else begin
      if (wr_en_q && !fifo_full && ~&beats_q) beats_q <= beats_q + 1'b1;
      if (state_q == HOLD && ~&stalls_q) stalls_q <= stalls_q + 1'b1;
    end
  assign stat_beats = beats_q;
  assign stat_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios with per-requester packet queues and a FIFO-side beat log.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;
  localparam int W = 8;
  localparam int N = 4;
  logic wr_clk = 1'b0;
  logic wr_rstn = 1'b0;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic fifo_full, fifo_wr_en, busy;
  logic [W-1:0] fifo_wr_data;
  logic [1:0] grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_beats, stat_stalls;
`endif
  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(4)) dut (
    .wr_clk      (wr_clk),
    .wr_rstn     (wr_rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats  (stat_beats),
    .stat_stalls (stat_stalls)
`endif
  );
  always #5 wr_clk = ~wr_clk;
  int tests = 0;
  int fails = 0;
  logic [8:0] pkt [N][16];
  int head [N];
  int tail [N];
  logic [7:0] outq [$];
  int srcq [$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = head[i] < tail[i];
      req_data[i*W +: W] = pkt[i][head[i] % 16][7:0];
      req_last[i] = pkt[i][head[i] % 16][8];
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    pkt[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    outq.delete();
    srcq.delete();
    drive();
  endtask

  task automatic cycle();
    logic [N-1:0] rdy;
    @(negedge wr_clk);
    if (wr_rstn && fifo_wr_en && !fifo_full) outq.push_back(fifo_wr_data);
    rdy = req_ready;
    if (rdy != '0) begin
      srcq.push_back(int'(grant_id));
      tests++;
      if (rdy !== (N'(1) << grant_id)) begin
        fails++;
        $display("FAIL ready_owner: req_ready=%b grant_id=%0d", rdy, grant_id);
      end
    end
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < N; i++) if (rdy[i]) head[i]++;
    drive();
  endtask

  task automatic apply_reset();
    wr_rstn = 1'b0;
    fifo_full = 1'b0;
    flush();
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rstn = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    bit pend;
    do begin
      cycle();
      c++;
      pend = fifo_wr_en || busy;
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) pend = 1;
    end while (pend && c < maxc);
    tests++;
    if (pend) begin
      fails++;
      $display("FAIL drain_timeout: still active after %0d cycles", c);
    end
  endtask

  task automatic test_reset();
    wr_rstn = 1'b0;
    fifo_full = 1'b0;
    flush();
    req_valid = '1;
    req_last = '1;
    req_data = '1;
    repeat (2) @(posedge wr_clk);
    #1;
    tests += 5;
    if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    if (fifo_wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data); end
    if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_two_packets();
    logic [7:0] ed [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
    int es [6] = '{0, 0, 0, 2, 2, 2};
    apply_reset();
    push(0, 8'hA0, 0); push(0, 8'hA1, 0); push(0, 8'hA2, 1);
    push(2, 8'hC0, 0); push(2, 8'hC1, 0); push(2, 8'hC2, 1);
    drive();
    drain(60);
    tests++;
    if (outq.size() != 6) begin fails++; $display("FAIL two_pkt_count: got %0d want 6", outq.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= outq.size() || i >= srcq.size() || outq[i] !== ed[i] || srcq[i] != es[i]) begin
        fails++;
        $display("FAIL two_pkt_beat[%0d]: got %h from %0d want %h from %0d", i,
                 i < outq.size() ? outq[i] : 8'hxx, i < srcq.size() ? srcq[i] : -1, ed[i], es[i]);
      end
    end
  endtask

  task automatic test_burst_cutoff();
    logic [7:0] ed [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h14, 8'h15};
    int es [8] = '{1, 1, 1, 1, 3, 3, 1, 1};
    apply_reset();
    for (int k = 0; k < 6; k++) push(1, 8'h10 + 8'(k), k == 5);
    push(3, 8'h30, 0); push(3, 8'h31, 1);
    drive();
    drain(80);
    tests++;
    if (outq.size() != 8) begin fails++; $display("FAIL cutoff_count: got %0d want 8", outq.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= outq.size() || i >= srcq.size() || outq[i] !== ed[i] || srcq[i] != es[i]) begin
        fails++;
        $display("FAIL cutoff_beat[%0d]: got %h from %0d want %h from %0d", i,
                 i < outq.size() ? outq[i] : 8'hxx, i < srcq.size() ? srcq[i] : -1, ed[i], es[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    for (int k = 0; k < 6; k++) push(0, 8'h50 + 8'(k), k == 5);
    drive();
    repeat (3) cycle();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests += 3;
      if (fifo_wr_en !== 1'b1) begin fails++; $display("FAIL stall_wr_en[%0d]: got %b want 1", k, fifo_wr_en); end
      if (fifo_wr_data !== 8'h51) begin fails++; $display("FAIL stall_data[%0d]: got %h want 51", k, fifo_wr_data); end
      if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, req_ready); end
      if (k > 0) begin
        tests++;
        if (dut.state_q !== HOLD) begin fails++; $display("FAIL stall_state[%0d]: got %0d want HOLD", k, dut.state_q); end
      end
      cycle();
    end
    fifo_full = 1'b0;
    #1;
    tests++;
    if (dut.state_q !== HOLD || fifo_wr_data !== 8'h51) begin
      fails++;
      $display("FAIL stall_release: state %0d data %h want HOLD 51", dut.state_q, fifo_wr_data);
    end
    drain(60);
    tests++;
    if (outq.size() != 6) begin fails++; $display("FAIL stall_count: got %0d want 6", outq.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= outq.size() || outq[i] !== 8'h50 + 8'(i)) begin
        fails++;
        $display("FAIL stall_beat[%0d]: got %h want %h", i, i < outq.size() ? outq[i] : 8'hxx, 8'h50 + 8'(i));
      end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    tests += 2;
    if (stat_stalls !== 16'd5) begin fails++; $display("FAIL stat_stalls: got %0d want 5", stat_stalls); end
    if (stat_beats !== 16'd6) begin fails++; $display("FAIL stat_beats: got %0d want 6", stat_beats); end
`endif
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) push(i, {4'(i), 4'(k)}, 1);
    drive();
    drain(120);
    tests++;
    if (outq.size() != 12) begin fails++; $display("FAIL rr_count: got %0d want 12", outq.size()); end
    for (int n = 0; n < 12; n++) begin
      tests++;
      if (n >= outq.size() || n >= srcq.size() || srcq[n] != n % 4 || outq[n] !== {4'(n % 4), 4'(n / 4)}) begin
        fails++;
        $display("FAIL rr_beat[%0d]: got %h from %0d want %h from %0d", n,
                 n < outq.size() ? outq[n] : 8'hxx, n < srcq.size() ? srcq[n] : -1, {4'(n % 4), 4'(n / 4)}, n % 4);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] ed [2] = '{8'h0A, 8'h33};
    int es [2] = '{0, 3};
    apply_reset();
    for (int k = 0; k < 4; k++) push(2, 8'h20 + 8'(k), k == 3);
    drive();
    repeat (3) cycle();
    tests++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h21) begin
      fails++;
      $display("FAIL midrst_pre: en %b data %h want 1 21", fifo_wr_en, fifo_wr_data);
    end
    wr_rstn = 1'b0;
    #1;
    tests += 5;
    if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL midrst_wr_en: got %b want 0", fifo_wr_en); end
    if (fifo_wr_data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h want 00", fifo_wr_data); end
    if (grant_id !== 2'd0) begin fails++; $display("FAIL midrst_grant: got %0d want 0", grant_id); end
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
    flush();
    @(posedge wr_clk);
    #1;
    wr_rstn = 1'b1;
    push(3, 8'h33, 1);
    push(0, 8'h0A, 1);
    drive();
    drain(40);
    tests++;
    if (outq.size() != 2) begin fails++; $display("FAIL midrst_count: got %0d want 2", outq.size()); end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (i >= outq.size() || i >= srcq.size() || outq[i] !== ed[i] || srcq[i] != es[i]) begin
        fails++;
        $display("FAIL midrst_beat[%0d]: got %h from %0d want %h from %0d", i,
                 i < outq.size() ? outq[i] : 8'hxx, i < srcq.size() ? srcq[i] : -1, ed[i], es[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_packets();
    test_burst_cutoff();
    test_full_stall();
    test_round_robin();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
